// File: rtl/alu_rs_pkg.sv
// Shared types for the ALU reservation station.
//   entry_state_e : lifecycle of one station slot.
//   rs_entry_t    : per-slot control bits (state plus operand-ready flags);
//                   the width-parameterised payload lives in the top module.
package alu_rs_pkg;

  typedef enum logic [1:0] {
    FREE    = 2'd0,
    WAITING = 2'd1,
    READY   = 2'd2
  } entry_state_e;

  typedef struct packed {
    entry_state_e state;
    logic         op1_valid;
    logic         op2_valid;
  } rs_entry_t;

  localparam rs_entry_t RS_ENTRY_EMPTY = '{state: FREE, op1_valid: 1'b0, op2_valid: 1'b0};

endpackage

// File: rtl/alu_rs_age_picker.sv
// Oldest-ready selector built on an age matrix.
//   clk_i, rst_i   : clock, synchronous active-high reset (clears the matrix)
//   alloc_i        : a slot is being written by dispatch this cycle
//   alloc_idx_i    : index of that slot; it becomes the youngest entry
//   ready_i        : per-slot READY flags
//   pick_idx_o     : index of the oldest READY slot (0 when none is READY)
// r_older[i][j] = 1 means slot i was dispatched before slot j.
module alu_rs_age_picker
  import alu_rs_pkg::*;
#(
  parameter int NumEntries = 4,
  parameter int IdxW       = 2
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  alloc_i,
  input  logic [IdxW-1:0]       alloc_idx_i,
  input  logic [NumEntries-1:0] ready_i,
  output logic [IdxW-1:0]       pick_idx_o
);

  logic [NumEntries-1:0] r_older [NumEntries];
  logic [NumEntries-1:0] w_win;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < NumEntries; i++) r_older[i] <= '0;
    end else if (alloc_i) begin
      // The new slot is younger than every other slot.
      for (int i = 0; i < NumEntries; i++) begin
        for (int j = 0; j < NumEntries; j++) begin
          if (IdxW'(i) == alloc_idx_i)      r_older[i][j] <= 1'b0;
          else if (IdxW'(j) == alloc_idx_i) r_older[i][j] <= 1'b1;
        end
      end
    end
  end

  always_comb begin
    w_win      = '0;
    pick_idx_o = '0;
    for (int i = 0; i < NumEntries; i++) begin
      w_win[i] = ready_i[i];
      for (int j = 0; j < NumEntries; j++) begin
        if (j != i && ready_i[j] && !r_older[i][j]) w_win[i] = 1'b0;
      end
    end
    for (int i = NumEntries - 1; i >= 0; i--) begin
      if (w_win[i]) pick_idx_o = IdxW'(i);
    end
  end

endmodule

// File: rtl/alu_reservation_station.sv
// ALU reservation station: buffers dispatched instructions, snoops the CDB for
// pending operands and issues the oldest READY instruction to the ALU.
//   clk_i, rst_i, flush_i           : clock, sync active-high reset, flush
//   dispatch_*                      : valid/ready handshake plus instruction fields
//   dispatch_opN_valid/tag/value_i  : operand value when valid, else producer tag
//   cdb_valid_i/tag_i/data_i        : common data bus broadcast
//   issue_valid_o/issue_ready_i     : issue handshake to the ALU
//   issue_operation_o, operand1_o, operand2_o, immediate_o, pc_o,
//   issue_dest_tag_o                : issued instruction (zero when not valid)
module alu_reservation_station
  import alu_rs_pkg::*;
#(
  parameter int DatapathWidth     = 32,
  parameter int AluOperationWidth = 5,
  parameter int TagWidth          = 3,
  parameter int NumEntries        = 4
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         flush_i,
  input  logic                         dispatch_valid_i,
  output logic                         dispatch_ready_o,
  input  logic [AluOperationWidth-1:0] dispatch_operation_i,
  input  logic [TagWidth-1:0]          dispatch_dest_tag_i,
  input  logic [DatapathWidth-1:0]     dispatch_immediate_i,
  input  logic [DatapathWidth-1:0]     dispatch_pc_i,
  input  logic                         dispatch_op1_valid_i,
  input  logic [TagWidth-1:0]          dispatch_op1_tag_i,
  input  logic [DatapathWidth-1:0]     dispatch_op1_value_i,
  input  logic                         dispatch_op2_valid_i,
  input  logic [TagWidth-1:0]          dispatch_op2_tag_i,
  input  logic [DatapathWidth-1:0]     dispatch_op2_value_i,
  input  logic                         cdb_valid_i,
  input  logic [TagWidth-1:0]          cdb_tag_i,
  input  logic [DatapathWidth-1:0]     cdb_data_i,
  output logic                         issue_valid_o,
  input  logic                         issue_ready_i,
  output logic [AluOperationWidth-1:0] issue_operation_o,
  output logic [DatapathWidth-1:0]     operand1_o,
  output logic [DatapathWidth-1:0]     operand2_o,
  output logic [DatapathWidth-1:0]     immediate_o,
  output logic [DatapathWidth-1:0]     pc_o,
  output logic [TagWidth-1:0]          issue_dest_tag_o
);

  localparam int IdxW = (NumEntries > 1) ? $clog2(NumEntries) : 1;

  rs_entry_t                    r_entry     [NumEntries];
  logic [AluOperationWidth-1:0] r_operation [NumEntries];
  logic [TagWidth-1:0]          r_dest_tag  [NumEntries];
  logic [DatapathWidth-1:0]     r_imm       [NumEntries];
  logic [DatapathWidth-1:0]     r_pc        [NumEntries];
  logic [TagWidth-1:0]          r_op1_tag   [NumEntries];
  logic [TagWidth-1:0]          r_op2_tag   [NumEntries];
  logic [DatapathWidth-1:0]     r_op1_data  [NumEntries];
  logic [DatapathWidth-1:0]     r_op2_data  [NumEntries];
  logic                         r_lock;
  logic [IdxW-1:0]              r_lock_idx;

  logic [NumEntries-1:0]    w_free, w_ready, w_cap1, w_cap2;
  logic [IdxW-1:0]          w_alloc_idx, w_pick_idx, w_issue_idx;
  logic                     w_dispatch_fire, w_issue_fire;
  logic                     w_d_op1_vld, w_d_op2_vld;
  logic [DatapathWidth-1:0] w_d_op1_val, w_d_op2_val;

  always_comb begin
    w_free      = '0;
    w_ready     = '0;
    w_cap1      = '0;
    w_cap2      = '0;
    w_alloc_idx = '0;
    for (int i = 0; i < NumEntries; i++) begin
      w_free[i]  = (r_entry[i].state == FREE);
      w_ready[i] = (r_entry[i].state == READY);
      w_cap1[i]  = cdb_valid_i && (r_entry[i].state == WAITING) &&
                   !r_entry[i].op1_valid && (cdb_tag_i == r_op1_tag[i]);
      w_cap2[i]  = cdb_valid_i && (r_entry[i].state == WAITING) &&
                   !r_entry[i].op2_valid && (cdb_tag_i == r_op2_tag[i]);
    end
    for (int i = NumEntries - 1; i >= 0; i--) begin
      if (w_free[i]) w_alloc_idx = IdxW'(i);
    end
  end

  // Both handshakes depend only on registered state, so issue_ready_i never
  // reaches dispatch_ready_o.
  assign dispatch_ready_o = |w_free;
  assign issue_valid_o    = |w_ready;
  assign w_dispatch_fire  = dispatch_valid_i && dispatch_ready_o && !flush_i;
  // A stalled issue stays on its slot even if an older slot becomes READY.
  assign w_issue_idx      = r_lock ? r_lock_idx : w_pick_idx;
  assign w_issue_fire     = issue_valid_o && issue_ready_i && !flush_i;

  // A broadcast in the dispatch cycle is captured directly so it is never lost.
  assign w_d_op1_vld = dispatch_op1_valid_i || (cdb_valid_i && cdb_tag_i == dispatch_op1_tag_i);
  assign w_d_op2_vld = dispatch_op2_valid_i || (cdb_valid_i && cdb_tag_i == dispatch_op2_tag_i);
  assign w_d_op1_val = dispatch_op1_valid_i ? dispatch_op1_value_i : cdb_data_i;
  assign w_d_op2_val = dispatch_op2_valid_i ? dispatch_op2_value_i : cdb_data_i;

  alu_rs_age_picker #(
    .NumEntries (NumEntries),
    .IdxW       (IdxW)
  ) u_age_picker (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .alloc_i     (w_dispatch_fire),
    .alloc_idx_i (w_alloc_idx),
    .ready_i     (w_ready),
    .pick_idx_o  (w_pick_idx)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i || flush_i) begin
      for (int i = 0; i < NumEntries; i++) r_entry[i] <= RS_ENTRY_EMPTY;
      r_lock     <= 1'b0;
      r_lock_idx <= '0;
    end else begin
      r_lock     <= issue_valid_o && !issue_ready_i;
      r_lock_idx <= w_issue_idx;
      for (int i = 0; i < NumEntries; i++) begin
        case (r_entry[i].state)
          FREE: begin
            if (w_dispatch_fire && w_alloc_idx == IdxW'(i)) begin
              r_entry[i].op1_valid <= w_d_op1_vld;
              r_entry[i].op2_valid <= w_d_op2_vld;
              r_entry[i].state     <= (w_d_op1_vld && w_d_op2_vld) ? READY : WAITING;
            end
          end
          WAITING: begin
            // Operand flags set by a capture promote the slot one cycle later,
            // so a broadcast never forwards straight to issue.
            if (w_cap1[i]) r_entry[i].op1_valid <= 1'b1;
            if (w_cap2[i]) r_entry[i].op2_valid <= 1'b1;
            if (r_entry[i].op1_valid && r_entry[i].op2_valid) r_entry[i].state <= READY;
          end
          READY: begin
            if (w_issue_fire && w_issue_idx == IdxW'(i)) r_entry[i] <= RS_ENTRY_EMPTY;
          end
          default: r_entry[i] <= RS_ENTRY_EMPTY;
        endcase
      end
    end
  end

  always_ff @(posedge clk_i) begin
    for (int i = 0; i < NumEntries; i++) begin
      if (w_dispatch_fire && w_alloc_idx == IdxW'(i)) begin
        r_operation[i] <= dispatch_operation_i;
        r_dest_tag[i]  <= dispatch_dest_tag_i;
        r_imm[i]       <= dispatch_immediate_i;
        r_pc[i]        <= dispatch_pc_i;
        r_op1_tag[i]   <= dispatch_op1_tag_i;
        r_op2_tag[i]   <= dispatch_op2_tag_i;
        r_op1_data[i]  <= w_d_op1_val;
        r_op2_data[i]  <= w_d_op2_val;
      end else begin
        if (w_cap1[i]) r_op1_data[i] <= cdb_data_i;
        if (w_cap2[i]) r_op2_data[i] <= cdb_data_i;
      end
    end
  end

  always_comb begin
    issue_operation_o = '0;
    operand1_o        = '0;
    operand2_o        = '0;
    immediate_o       = '0;
    pc_o              = '0;
    issue_dest_tag_o  = '0;
    if (issue_valid_o) begin
      issue_operation_o = r_operation[w_issue_idx];
      operand1_o        = r_op1_data[w_issue_idx];
      operand2_o        = r_op2_data[w_issue_idx];
      immediate_o       = r_imm[w_issue_idx];
      pc_o              = r_pc[w_issue_idx];
      issue_dest_tag_o  = r_dest_tag[w_issue_idx];
    end
  end

endmodule
